// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, store-buffer entry type and access-length helper
package mem_pkg;

  localparam int MEM_AW = 32;

  localparam logic [2:0] MEM_B   = 3'b000;
  localparam logic [2:0] MEM_H   = 3'b001;
  localparam logic [2:0] MEM_W   = 3'b010;
  localparam int         MEM_UNS = 2;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [31:0]       wdata;
    logic [2:0]        size;
  } sb_entry_t;

  function automatic logic [2:0] access_len(input logic [2:0] size);
    if (size[1]) return 3'd4;
    else if (size[0]) return 3'd2;
    else return 3'd1;
  endfunction

endpackage

// File: rtl/store_buffer_lsu_if.sv
// rtl/store_buffer_lsu_if.sv - MEM-stage request/response bundle between pipeline and LSU
interface store_buffer_lsu_if #(parameter int AW = 32);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_u_b_h_w;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_u_b_h_w,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_u_b_h_w,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/store_buffer_lsu_sb_fifo.sv
// rtl/store_buffer_lsu_sb_fifo.sv - posted-store FIFO exposing every live entry for hazard compare
module sb_fifo
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  sb_entry_t         push_entry,
  input  logic              pop,
  output sb_entry_t         head,
  output logic [MEM_AW-1:0] entry_addr [DEPTH],
  output logic [2:0]        entry_size [DEPTH],
  output logic [DEPTH-1:0]  valid,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  sb_entry_t         mem_q [DEPTH];
  sb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem_q[i].addr;
      entry_size[i] = mem_q[i].size;
      valid[i]      = {1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/store_buffer_lsu.sv
// rtl/store_buffer_lsu.sv - load/store front end: posted store buffer, load priority, overlap stall
// Optional misaligned-access trap under LSU_MISALIGN_TRAP_EN.
module store_buffer_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = MEM_AW
) (
  input  logic                clk,
  input  logic                rst,
  store_buffer_lsu_if.slave   bus,
  output logic                sb_empty,
  output logic                misalign_err,
  output logic [AW-1:0]       ram_addra,
  output logic [31:0]         ram_dina,
  output logic                ram_wea,
  output logic [2:0]          ram_u_b_h_w,
  input  logic [31:0]         ram_douta
);

  localparam int CW = $clog2(DEPTH) + 1;

  sb_entry_t         head;
  sb_entry_t         push_entry;
  logic [MEM_AW-1:0] entry_addr [DEPTH];
  logic [2:0]        entry_size [DEPTH];
  logic [DEPTH-1:0]  entry_valid;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              hazard, trap, load_acc, store_acc, drain;

  // Two accesses collide when their covered word ranges intersect.
  function automatic logic overlaps(input logic [MEM_AW-1:0] a, input logic [2:0] sa,
                                    input logic [MEM_AW-1:0] b, input logic [2:0] sb);
    logic [MEM_AW-1:0] a_end, b_end;
    a_end = a + {{(MEM_AW-3){1'b0}}, access_len(sa)} - 1'b1;
    b_end = b + {{(MEM_AW-3){1'b0}}, access_len(sb)} - 1'b1;
    return (a[MEM_AW-1:2] <= b_end[MEM_AW-1:2]) && (b[MEM_AW-1:2] <= a_end[MEM_AW-1:2]);
  endfunction

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && overlaps(entry_addr[i], entry_size[i], bus.req_addr, bus.req_u_b_h_w)) begin
        hazard = 1'b1;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [1:0] lsb, input logic [2:0] size);
    if (size[1]) return lsb != 2'b00;
    else if (size[0]) return lsb[0];
    else return 1'b0;
  endfunction

  assign trap = bus.req_valid & is_misaligned(bus.req_addr[1:0], bus.req_u_b_h_w);
`else
  assign trap = 1'b0;
`endif

  // A store only drains when no request is taken, so back-to-back stores fill the buffer.
  assign load_acc  = bus.req_valid & ~bus.req_we & ~hazard & ~trap;
  assign store_acc = bus.req_valid &  bus.req_we & ~fifo_full & ~trap;
  assign drain     = ~fifo_empty & ~load_acc & ~store_acc & ~trap;

  assign push_entry = '{addr: bus.req_addr, wdata: bus.req_wdata, size: bus.req_u_b_h_w};

  sb_fifo #(.DEPTH(DEPTH)) u_sb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (store_acc),
    .push_entry (push_entry),
    .pop        (drain),
    .head       (head),
    .entry_addr (entry_addr),
    .entry_size (entry_size),
    .valid      (entry_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign bus.req_ready = load_acc | store_acc | trap;
  assign bus.rsp_valid = load_acc;
  assign bus.rsp_rdata = ram_douta;

  assign ram_wea      = drain;
  assign ram_addra    = load_acc ? bus.req_addr : head.addr;
  assign ram_u_b_h_w  = load_acc ? bus.req_u_b_h_w : head.size;
  assign ram_dina     = head.wdata;
  assign sb_empty     = (fifo_count == '0);
  assign misalign_err = trap;

endmodule

// File: tb/tb_store_buffer_lsu.sv
// tb/tb_store_buffer_lsu.sv - directed bench with load-response and RAM-write scoreboards
module tb_store_buffer_lsu;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sb_empty, misalign_err, ram_wea;
  logic [31:0] ram_addra, ram_dina, ram_douta;
  logic [2:0]  ram_u_b_h_w;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rq [$];
  sb_entry_t   wq [$];

  logic [7:0]  mem [256];
  logic        init_done = 1'b0;

  always #5 clk = ~clk;

  store_buffer_lsu_if #(.AW(32)) bus ();

  store_buffer_lsu #(.DEPTH(4), .AW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sb_empty     (sb_empty),
    .misalign_err (misalign_err),
    .ram_addra    (ram_addra),
    .ram_dina     (ram_dina),
    .ram_wea      (ram_wea),
    .ram_u_b_h_w  (ram_u_b_h_w),
    .ram_douta    (ram_douta)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM model: byte array initialised to its own index; out-of-range bytes read 0.
  always_comb begin
    logic [31:0] a;
    logic [7:0]  b [4];
    for (int k = 0; k < 4; k++) begin
      a    = ram_addra + 32'(k);
      b[k] = (a < 32'd256) ? mem[a[7:0]] : 8'h00;
    end
    if (ram_u_b_h_w[1])      ram_douta = {b[3], b[2], b[1], b[0]};
    else if (ram_u_b_h_w[0]) ram_douta = {{16{~ram_u_b_h_w[MEM_UNS] & b[1][7]}}, b[1], b[0]};
    else                     ram_douta = {{24{~ram_u_b_h_w[MEM_UNS] & b[0][7]}}, b[0]};
  end

  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      init_done <= 1'b1;
    end else if (!rst && ram_wea) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed=%h expected=none", ram_addra);
      end else begin
        sb_entry_t e;
        e = wq.pop_front();
        chk("wr_addr", ram_addra, e.addr);
        chk("wr_data", ram_dina, e.wdata);
        chk("wr_size", 32'(ram_u_b_h_w), 32'(e.size));
      end
      for (int k = 0; k < 4; k++) begin
        if (k < int'(access_len(ram_u_b_h_w)) && (ram_addra + 32'(k)) < 32'd256)
          mem[8'(ram_addra + 32'(k))] <= ram_dina[8*k +: 8];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz,
                          input int exp_stall, input string tag);
    int   stalls = 0;
    logic done   = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a;
    bus.req_wdata = d;    bus.req_u_b_h_w = sz;
    for (int i = 0; i < 16 && !done; i++) begin
      #7;
      if (bus.req_ready) begin
        done = 1'b1;
        wq.push_back('{addr: a, wdata: d, size: sz});
      end else begin
        stalls++;
        chk({tag, "_stall_drain"}, 32'(ram_wea), 32'd1);
      end
      next_cycle();
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    chk({tag, "_accepted"}, 32'(done), 32'd1);
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp,
                         input int exp_stall, input string tag);
    int   stalls = 0;
    logic done   = 1'b0;
    rq.push_back(exp);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
    bus.req_wdata = 32'h0; bus.req_u_b_h_w = sz;
    for (int i = 0; i < 16 && !done; i++) begin
      #7;
      if (bus.req_ready) begin
        done = 1'b1;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_no_drain"}, 32'(ram_wea), 32'd0);
        chk({tag, "_ram_addr"}, ram_addra, a);
        chk({tag, "_ram_size"}, 32'(ram_u_b_h_w), 32'(sz));
        chk({tag, "_misalign"}, 32'(misalign_err), 32'd0);
        if (bus.rsp_valid && rq.size() > 0) chk({tag, "_rdata"}, bus.rsp_rdata, rq.pop_front());
      end else begin
        stalls++;
        chk({tag, "_stall_drain"}, 32'(ram_wea), 32'd1);
      end
      next_cycle();
    end
    bus.req_valid = 1'b0;
    chk({tag, "_accepted"}, 32'(done), 32'd1);
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_u_b_h_w = MEM_B;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_ram_wea", 32'(ram_wea), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    next_cycle();

    // Three stores pending, then reset discards them.
    do_store(32'h80, 32'h11111111, MEM_W, 0, "t1_st0");
    do_store(32'h84, 32'h22222222, MEM_W, 0, "t1_st1");
    do_store(32'h88, 32'h33333333, MEM_W, 0, "t1_st2");
    rst = 1'b1;
    wq.delete();
    #7;
    chk("t1_sb_empty", 32'(sb_empty), 32'd1);
    chk("t1_ram_wea", 32'(ram_wea), 32'd0);
    next_cycle();
    rst = 1'b0;
    repeat (3) next_cycle();
    do_load(32'h80, MEM_W, 32'h83828180, 0, "t1_ld80");
    do_load(32'h88, MEM_W, 32'h8B8A8988, 0, "t1_ld88");

    // Store then dependent load.
    do_store(32'h10, 32'hDEADBEEF, MEM_W, 0, "t2_sw");
    do_load(32'h10, MEM_W, 32'hDEADBEEF, 1, "t2_lw");

    // Five back-to-back byte stores overfill DEPTH=4.
    for (int i = 0; i < 5; i++)
      do_store(32'h40 + 32'(i), 32'(8'h11 * (i + 1)), MEM_B, (i == 4) ? 1 : 0, $sformatf("t3_sb%0d", i));
    #7;
    chk("t3_not_empty", 32'(sb_empty), 32'd0);
    next_cycle();
    repeat (3) next_cycle();
    #7;
    chk("t3_drained", 32'(sb_empty), 32'd1);
    next_cycle();
    do_load(32'h40, MEM_W, 32'h44332211, 0, "t3_lw40");
    do_load(32'h44, MEM_B | 3'b100, 32'h00000055, 0, "t3_lbu44");

    // Non-overlapping load wins the port; store drains on the next idle cycle.
    do_store(32'h20, 32'hCAFEF00D, MEM_W, 0, "t4_sw");
    do_load(32'h30, MEM_W, 32'h33323130, 0, "t4_lw30");
    #7;
    chk("t4_idle_drain", 32'(ram_wea), 32'd1);
    chk("t4_idle_addr", ram_addra, 32'h20);
    next_cycle();
    do_load(32'h20, MEM_W, 32'hCAFEF00D, 0, "t4_lw20");

    // Half store, then byte load of its upper byte.
    do_store(32'h7E, 32'h0000A5C3, MEM_H, 0, "t5_sh");
    do_load(32'h7F, MEM_B | 3'b100, 32'h000000A5, 1, "t5_lbu");
    do_load(32'h7F, MEM_B, 32'hFFFFFFA5, 0, "t5_lb");
    do_load(32'h7E, MEM_H, 32'hFFFFA5C3, 0, "t5_lh");

    do_load(32'h1000, MEM_W, 32'h00000000, 0, "oor_lw");

    // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h13; bus.req_u_b_h_w = MEM_W;
    #7;
    chk("t6_misalign", 32'(misalign_err), 32'd1);
    chk("t6_ready", 32'(bus.req_ready), 32'd1);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_ram_wea", 32'(ram_wea), 32'd0);
    next_cycle();
    bus.req_valid = 1'b0;
    #7;
    chk("t6_misalign_clear", 32'(misalign_err), 32'd0);
    next_cycle();
`else
    do_load(32'h13, MEM_W, 32'h161514DE, 0, "t6_lw13");
`endif

    repeat (2) next_cycle();
    chk("end_wq_empty", 32'(wq.size()), 32'd0);
    chk("end_rq_empty", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
